alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RESET_PRIORITY, default 0, requester that wins the first simultaneous request after reset.
REQ-002 clk_in  input  1  single clock; all state changes on rising edge.
REQ-003 rst_in  input  1  reset, asynchronous, active-high.
REQ-004 reqN_valid_in  input  1  requester N (N=0,1) presents an operation.
REQ-005 reqN_ready_out  output  1  arbiter accepts requester N's operation this cycle.
REQ-006 reqN_opcode_in  input  7  RISC-V opcode of requester N.
REQ-007 reqN_funct3_in  input  3  funct3 of requester N.
REQ-008 reqN_funct7_in  input  7  funct7 of requester N.
REQ-009 reqN_rs1_value_in  input  32  first operand of requester N.
REQ-010 reqN_operand_in  input  32  second operand (register or sign-extended immediate) of requester N.
REQ-011 rspN_valid_out  output  1  result for requester N is available.
REQ-012 rspN_ready_in  input  1  requester N consumes the result.
REQ-013 rsp_result_out  output  32  result, shared by both response channels.
REQ-014 rsp_err_out  output  1  accepted opcode was neither 0110011 nor 0010011.
REQ-015 alu_opcode_out, alu_funct3_out, alu_funct7_out  output  7/3/7  fields driven to the shared ALU.
REQ-016 alu_rs1_value_out, alu_operand_out  output  32/32  operands driven to the shared ALU.
REQ-017 alu_result_in  input  32  combinational ALU result.

Function
REQ-018 The FSM SHALL have states IDLE, EXEC, RESP; reset state IDLE.
REQ-019 reqN_ready_out SHALL be high only in IDLE, and only for the granted requester.
REQ-020 In IDLE, when exactly one reqN_valid_in is high, that requester SHALL be granted.
REQ-021 In IDLE, when both are high, the requester named by the priority pointer SHALL be granted.
REQ-022 After every grant, the pointer SHALL switch to the non-granted requester (round-robin).
REQ-023 On a grant (valid&ready at edge T), the fields SHALL be latched, the winner ID stored, and the state SHALL become EXEC.
REQ-024 In EXEC, alu_* outputs SHALL drive the latched fields; at edge T+1, alu_result_in SHALL be registered and the state SHALL become RESP.
REQ-025 The ALU outputs SHALL hold the latched fields in all states, so they change only on a grant.
REQ-026 In RESP, rspN_valid_out SHALL be high for the stored ID only, so the first assertion occurs in cycle T+2.
REQ-027 rsp_result_out and rsp_err_out SHALL stay stable while rspN_valid_out is high and rspN_ready_in is low.
REQ-028 On valid&ready in RESP, the state SHALL become IDLE; a new grant is possible no earlier than the following cycle, giving a throughput of one operation per 3 cycles.
REQ-029 When the latched opcode is not 0110011 or 0010011, rsp_result_out SHALL be 0 and rsp_err_out SHALL be 1; otherwise rsp_err_out SHALL be 0.
REQ-030 reqN_valid_in deasserting while not granted SHALL be legal and SHALL have no effect.
REQ-031 rsp_result_out and rsp_err_out SHALL be 0 outside RESP.

Reset
REQ-032 Asserting rst_in SHALL immediately force state IDLE and set the pointer to RESET_PRIORITY.
REQ-033 Asserting rst_in SHALL also force all outputs (ready, valid, result, err, alu_*) and the latched registers to 0.
REQ-034 A transaction in EXEC or RESP at reset SHALL be dropped, with no response issued after deassertion.

Structure
REQ-035 The opcode constants (0110011, 0010011) and the state encoding SHALL live in a shared package, also used by the ALU.
REQ-036 The block SHALL be one module with no sub-modules; the ALU is instantiated beside it by the parent.

Verification
REQ-037 Directed test (requester 0): opcode 0010011, funct3 000, rs1 5, operand 0xFFFFFFFD -> rsp0_valid_out at T+2, result 0x00000002, err 0.
REQ-038 Directed test (contention): after reset with RESET_PRIORITY 0, both valid with 1 continuously -> grants 0 then 1 then 0, and rsp1 carries 10-3=7 for a funct7 0x20 subtract.
REQ-039 Directed test (backpressure): hold rsp0_ready_in low 3 cycles -> valid and result held constant, req ready low, no new grant.
REQ-040 Directed test (illegal opcode): opcode 0000011 -> result 0x00000000, err 1.
REQ-041 Directed test (reset mid-operation): rst_in pulse during EXEC -> no rsp valid afterwards, requester-0 ready high in the first IDLE cycle with valid high.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter and the ALU beside it:
// the legal RISC-V ALU opcodes, the arbiter state encoding and the latched request record.
package alu_arbiter_pkg;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] rs1_value;
        logic [31:0] operand;
    } alu_req_t;

    function automatic logic is_alu_opcode(input logic [6:0] opcode);
        return (opcode == OPCODE_OP) || (opcode == OPCODE_OP_IMM);
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, response and shared-ALU signals around alu_arbiter.
// slave is the arbiter's view; master is the view of the requesters plus the ALU.
interface alu_arbiter_if;

    logic        req0_valid_in,     req1_valid_in;
    logic        req0_ready_out,    req1_ready_out;
    logic [6:0]  req0_opcode_in,    req1_opcode_in;
    logic [2:0]  req0_funct3_in,    req1_funct3_in;
    logic [6:0]  req0_funct7_in,    req1_funct7_in;
    logic [31:0] req0_rs1_value_in, req1_rs1_value_in;
    logic [31:0] req0_operand_in,   req1_operand_in;

    logic        rsp0_valid_out,    rsp1_valid_out;
    logic        rsp0_ready_in,     rsp1_ready_in;
    logic [31:0] rsp_result_out;
    logic        rsp_err_out;

    logic [6:0]  alu_opcode_out;
    logic [2:0]  alu_funct3_out;
    logic [6:0]  alu_funct7_out;
    logic [31:0] alu_rs1_value_out;
    logic [31:0] alu_operand_out;
    logic [31:0] alu_result_in;

    modport slave (
        input  req0_valid_in, req1_valid_in,
        output req0_ready_out, req1_ready_out,
        input  req0_opcode_in, req1_opcode_in,
        input  req0_funct3_in, req1_funct3_in,
        input  req0_funct7_in, req1_funct7_in,
        input  req0_rs1_value_in, req1_rs1_value_in,
        input  req0_operand_in, req1_operand_in,
        output rsp0_valid_out, rsp1_valid_out,
        input  rsp0_ready_in, rsp1_ready_in,
        output rsp_result_out, rsp_err_out,
        output alu_opcode_out, alu_funct3_out, alu_funct7_out,
        output alu_rs1_value_out, alu_operand_out,
        input  alu_result_in
    );

    modport master (
        output req0_valid_in, req1_valid_in,
        input  req0_ready_out, req1_ready_out,
        output req0_opcode_in, req1_opcode_in,
        output req0_funct3_in, req1_funct3_in,
        output req0_funct7_in, req1_funct7_in,
        output req0_rs1_value_in, req1_rs1_value_in,
        output req0_operand_in, req1_operand_in,
        input  rsp0_valid_out, rsp1_valid_out,
        output rsp0_ready_in, rsp1_ready_in,
        input  rsp_result_out, rsp_err_out,
        input  alu_opcode_out, alu_funct3_out, alu_funct7_out,
        input  alu_rs1_value_out, alu_operand_out,
        output alu_result_in
    );

endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each operation takes IDLE -> EXEC -> RESP, so the block sustains one operation per 3 cycles.
import alu_arbiter_pkg::*;

module alu_arbiter #(
    parameter int unsigned RESET_PRIORITY = 0
) (
    input  logic          clk_in,
    input  logic          rst_in,
    alu_arbiter_if.slave  bus
);

    localparam logic RESET_PTR = (RESET_PRIORITY != 0);

    arb_state_t  state, next_state;
    logic        prio_ptr;
    logic        grant_id;
    alu_req_t    req_q;
    logic [31:0] result_q;
    logic        err_q;

    alu_req_t    req0_fields, req1_fields;
    logic        any_valid, grant_sel, grant_fire, rsp_fire;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;

    assign req0_fields = {bus.req0_opcode_in, bus.req0_funct3_in, bus.req0_funct7_in,
                          bus.req0_rs1_value_in, bus.req0_operand_in};
    assign req1_fields = {bus.req1_opcode_in, bus.req1_funct3_in, bus.req1_funct7_in,
                          bus.req1_rs1_value_in, bus.req1_operand_in};

    // On contention the pointer decides; a lone requester wins regardless of the pointer.
    assign any_valid = bus.req0_valid_in | bus.req1_valid_in;
    assign grant_sel = (bus.req0_valid_in & bus.req1_valid_in) ? prio_ptr : bus.req1_valid_in;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        grant_fire = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_valid && !rst_in) begin
                    grant_fire = 1'b1;
                    req0_ready = ~grant_sel;
                    req1_ready = grant_sel;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp0_valid = ~grant_id;
                rsp1_valid = grant_id;
                rsp_fire   = grant_id ? bus.rsp1_ready_in : bus.rsp0_ready_in;
                if (rsp_fire) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Latched request and registered result; the ALU sees req_q in every state.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            prio_ptr <= RESET_PTR;
            grant_id <= 1'b0;
            req_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (grant_fire) begin
                req_q    <= grant_sel ? req1_fields : req0_fields;
                grant_id <= grant_sel;
                prio_ptr <= ~grant_sel;
            end
            if (state == ST_EXEC) begin
                result_q <= is_alu_opcode(req_q.opcode) ? bus.alu_result_in : 32'h0;
                err_q    <= ~is_alu_opcode(req_q.opcode);
            end
        end
    end

    assign bus.req0_ready_out    = req0_ready;
    assign bus.req1_ready_out    = req1_ready;
    assign bus.rsp0_valid_out    = rsp0_valid;
    assign bus.rsp1_valid_out    = rsp1_valid;
    assign bus.rsp_result_out    = (state == ST_RESP) ? result_q : 32'h0;
    assign bus.rsp_err_out       = (state == ST_RESP) ? err_q : 1'b0;
    assign bus.alu_opcode_out    = req_q.opcode;
    assign bus.alu_funct3_out    = req_q.funct3;
    assign bus.alu_funct7_out    = req_q.funct7;
    assign bus.alu_rs1_value_out = req_q.rs1_value;
    assign bus.alu_operand_out   = req_q.operand;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a vector table of single-requester operations against a
// small RV32I ALU model, plus hand sequences for contention, backpressure and mid-operation reset.
module tb_alu_arbiter;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    typedef struct {
        logic        req_id;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] rs1;
        logic [31:0] operand;
        logic [31:0] exp_result;
        logic        exp_err;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] model_result;
    int          total;
    int          bad;
    vec_t        vecs[11];

    alu_arbiter_if bus();

    alu_arbiter #(.RESET_PRIORITY(0)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU beside the arbiter; it ignores the opcode, so illegal ops still yield nonzero values.
    always_comb begin
        model_result = 32'h0;
        case (bus.alu_funct3_out)
            3'b000: model_result = (bus.alu_opcode_out == OP && bus.alu_funct7_out[5])
                                   ? bus.alu_rs1_value_out - bus.alu_operand_out
                                   : bus.alu_rs1_value_out + bus.alu_operand_out;
            3'b001: model_result = bus.alu_rs1_value_out << bus.alu_operand_out[4:0];
            3'b010: model_result = {31'b0, $signed(bus.alu_rs1_value_out) < $signed(bus.alu_operand_out)};
            3'b011: model_result = {31'b0, bus.alu_rs1_value_out < bus.alu_operand_out};
            3'b100: model_result = bus.alu_rs1_value_out ^ bus.alu_operand_out;
            3'b101: model_result = bus.alu_funct7_out[5]
                                   ? 32'($signed(bus.alu_rs1_value_out) >>> bus.alu_operand_out[4:0])
                                   : bus.alu_rs1_value_out >> bus.alu_operand_out[4:0];
            3'b110: model_result = bus.alu_rs1_value_out | bus.alu_operand_out;
            default: model_result = bus.alu_rs1_value_out & bus.alu_operand_out;
        endcase
    end
    assign bus.alu_result_in = model_result;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic setReq(input logic id, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] rs1, input logic [31:0] opnd);
        if (id) begin
            bus.req1_opcode_in = opc; bus.req1_funct3_in = f3; bus.req1_funct7_in = f7;
            bus.req1_rs1_value_in = rs1; bus.req1_operand_in = opnd;
        end else begin
            bus.req0_opcode_in = opc; bus.req0_funct3_in = f3; bus.req0_funct7_in = f7;
            bus.req0_rs1_value_in = rs1; bus.req0_operand_in = opnd;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        setReq(v.req_id, v.opcode, v.funct3, v.funct7, v.rs1, v.operand);
        setReq(~v.req_id, OP, 3'b000, 7'h00, 32'h0000DEAD, 32'h00000001);
        bus.req0_valid_in = ~v.req_id;
        bus.req1_valid_in = v.req_id;
        bus.rsp0_ready_in = 1'b1;
        bus.rsp1_ready_in = 1'b1;
    endtask

    task automatic clearRequests();
        bus.req0_valid_in = 1'b0;
        bus.req1_valid_in = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        clearRequests();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clearRequests();
        setReq(1'b0, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0);
        setReq(1'b1, 7'h0, 3'h0, 7'h0, 32'h0, 32'h0);
        bus.rsp0_ready_in = 1'b0;
        bus.rsp1_ready_in = 1'b0;

        vecs[0]  = '{1'b0, OP_IMM,     3'b000, 7'h00, 32'd5,        32'hFFFFFFFD, 32'h00000002, 1'b0};
        vecs[1]  = '{1'b1, OP,         3'b000, 7'h20, 32'd10,       32'd3,        32'h00000007, 1'b0};
        vecs[2]  = '{1'b0, OP,         3'b111, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0};
        vecs[3]  = '{1'b1, OP_IMM,     3'b110, 7'h00, 32'h00000001, 32'h00000010, 32'h00000011, 1'b0};
        vecs[4]  = '{1'b0, 7'b0000011, 3'b000, 7'h00, 32'd5,        32'd6,        32'h00000000, 1'b1};
        vecs[5]  = '{1'b1, OP,         3'b100, 7'h00, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 1'b0};
        vecs[6]  = '{1'b0, OP,         3'b001, 7'h00, 32'd1,        32'd4,        32'h00000010, 1'b0};
        vecs[7]  = '{1'b1, OP,         3'b010, 7'h00, 32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0};
        vecs[8]  = '{1'b0, OP,         3'b101, 7'h20, 32'h80000000, 32'd4,        32'hF8000000, 1'b0};
        vecs[9]  = '{1'b1, 7'b1100011, 3'b000, 7'h00, 32'd1,        32'd1,        32'h00000000, 1'b1};
        vecs[10] = '{1'b0, OP_IMM,     3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b0};

        // Reset state, with a requester already asking so ready must still stay low.
        bus.req0_valid_in = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_req0_ready", 32'(bus.req0_ready_out), 32'h0);
        checkOutput("reset_rsp0_valid", 32'(bus.rsp0_valid_out), 32'h0);
        checkOutput("reset_rsp1_valid", 32'(bus.rsp1_valid_out), 32'h0);
        checkOutput("reset_result", bus.rsp_result_out, 32'h0);
        checkOutput("reset_err", 32'(bus.rsp_err_out), 32'h0);
        checkOutput("reset_alu_opcode", 32'(bus.alu_opcode_out), 32'h0);
        checkOutput("reset_alu_rs1", bus.alu_rs1_value_out, 32'h0);
        bus.req0_valid_in = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_ready_win", i),
                        32'(vecs[i].req_id ? bus.req1_ready_out : bus.req0_ready_out), 32'h1);
            checkOutput($sformatf("v%0d_ready_lose", i),
                        32'(vecs[i].req_id ? bus.req0_ready_out : bus.req1_ready_out), 32'h0);
            @(posedge clk);
            #1;
            clearRequests();
            @(negedge clk);
            checkOutput($sformatf("v%0d_alu_opcode", i), 32'(bus.alu_opcode_out), 32'(vecs[i].opcode));
            checkOutput($sformatf("v%0d_alu_rs1", i), bus.alu_rs1_value_out, vecs[i].rs1);
            checkOutput($sformatf("v%0d_alu_operand", i), bus.alu_operand_out, vecs[i].operand);
            checkOutput($sformatf("v%0d_exec_rsp_valid", i),
                        32'({bus.rsp1_valid_out, bus.rsp0_valid_out}), 32'h0);
            checkOutput($sformatf("v%0d_exec_result", i), bus.rsp_result_out, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_rsp_valid", i),
                        32'({bus.rsp1_valid_out, bus.rsp0_valid_out}), vecs[i].req_id ? 32'h2 : 32'h1);
            checkOutput($sformatf("v%0d_result", i), bus.rsp_result_out, vecs[i].exp_result);
            checkOutput($sformatf("v%0d_err", i), 32'(bus.rsp_err_out), 32'(vecs[i].exp_err));
            @(negedge clk);
            checkOutput($sformatf("v%0d_idle_rsp_valid", i),
                        32'({bus.rsp1_valid_out, bus.rsp0_valid_out}), 32'h0);
            checkOutput($sformatf("v%0d_idle_result", i), bus.rsp_result_out, 32'h0);
            checkOutput($sformatf("v%0d_idle_err", i), 32'(bus.rsp_err_out), 32'h0);
        end

        // Contention: both requesters hold valid; grants must alternate 0,1,0 back to back.
        doReset();
        setReq(1'b0, OP, 3'b000, 7'h00, 32'd1, 32'd2);
        setReq(1'b1, OP, 3'b000, 7'h20, 32'd10, 32'd3);
        bus.req0_valid_in = 1'b1;
        bus.req1_valid_in = 1'b1;
        bus.rsp0_ready_in = 1'b1;
        bus.rsp1_ready_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("cont%0d_ready", k),
                        32'({bus.req1_ready_out, bus.req0_ready_out}), (k == 1) ? 32'h2 : 32'h1);
            @(negedge clk);
            checkOutput($sformatf("cont%0d_exec_ready", k),
                        32'({bus.req1_ready_out, bus.req0_ready_out}), 32'h0);
            @(negedge clk);
            checkOutput($sformatf("cont%0d_rsp_valid", k),
                        32'({bus.rsp1_valid_out, bus.rsp0_valid_out}), (k == 1) ? 32'h2 : 32'h1);
            checkOutput($sformatf("cont%0d_result", k), bus.rsp_result_out, (k == 1) ? 32'd7 : 32'd3);
            if (k == 2) clearRequests();
            @(negedge clk);
        end

        // Backpressure: response held for 3 cycles while requester 1 waits.
        setReq(1'b0, OP_IMM, 3'b000, 7'h00, 32'd100, 32'd23);
        bus.rsp0_ready_in = 1'b0;
        bus.req0_valid_in = 1'b1;
        #1;
        checkOutput("bp_grant_ready0", 32'(bus.req0_ready_out), 32'h1);
        @(posedge clk);
        #1;
        bus.req0_valid_in = 1'b0;
        bus.req1_valid_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_first_valid", 32'(bus.rsp0_valid_out), 32'h1);
        checkOutput("bp_first_result", bus.rsp_result_out, 32'd123);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("bp%0d_valid", c), 32'(bus.rsp0_valid_out), 32'h1);
            checkOutput($sformatf("bp%0d_result", c), bus.rsp_result_out, 32'd123);
            checkOutput($sformatf("bp%0d_err", c), 32'(bus.rsp_err_out), 32'h0);
            checkOutput($sformatf("bp%0d_req_ready", c),
                        32'({bus.req1_ready_out, bus.req0_ready_out}), 32'h0);
        end
        bus.rsp0_ready_in = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(bus.rsp0_valid_out), 32'h0);
        checkOutput("bp_release_ready1", 32'(bus.req1_ready_out), 32'h1);
        bus.req1_valid_in = 1'b0;
        @(negedge clk);
        checkOutput("bp_withdraw_ready1", 32'(bus.req1_ready_out), 32'h0);
        checkOutput("bp_withdraw_rsp1", 32'(bus.rsp1_valid_out), 32'h0);

        // Reset during EXEC drops the operation; requester 0 regains ready on the first IDLE cycle.
        setReq(1'b0, OP, 3'b110, 7'h00, 32'h00000055, 32'h000000AA);
        bus.req0_valid_in = 1'b1;
        #1;
        checkOutput("mid_grant_ready0", 32'(bus.req0_ready_out), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_alu_opcode", 32'(bus.alu_opcode_out), 32'h0);
        checkOutput("mid_rst_alu_rs1", bus.alu_rs1_value_out, 32'h0);
        checkOutput("mid_rst_ready0", 32'(bus.req0_ready_out), 32'h0);
        checkOutput("mid_rst_rsp0", 32'(bus.rsp0_valid_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_after_ready0", 32'(bus.req0_ready_out), 32'h1);
        checkOutput("mid_after_rsp0", 32'(bus.rsp0_valid_out), 32'h0);
        bus.req0_valid_in = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput($sformatf("mid%0d_rsp_valid", c),
                        32'({bus.rsp1_valid_out, bus.rsp0_valid_out}), 32'h0);
            checkOutput($sformatf("mid%0d_result", c), bus.rsp_result_out, 32'h0);
        end
        checkOutput("mid_alu_rs1_held", bus.alu_rs1_value_out, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
